// File: rtl/uart_rx_sampling_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_sampling_controller
//
// Receive-side sequencer for a UART. The raw line is brought into the clock
// domain through a two-flop synchronizer. A falling level in IDLE starts a
// frame, and the start bit is checked at its centre. Each data bit is then
// sampled at its centre. Every sampled bit is handed to a downstream SIPO
// shift register through a one-cycle shift strobe. The SIPO assembles the
// byte LSB first. Last, the stop bit is checked.
//
// Configuration macro:
//   RX_MAJORITY_VOTE_EN - when defined, each sample is the majority of the
//                         last three synchronized line values. When undefined,
//                         each sample is the synchronized line value itself.
//                         Evaluation timing is the same in both builds.
//
// Parameters:
//   INPUT_DATA_WIDTH  data bits per frame (must match the SIPO width)
//   CLOCKS_PER_BIT    clk cycles per bit period (even, >= 4)
//
// Ports:
//   clk                in   system clock, rising edge
//   reset              in   synchronous active-high reset
//   serial_in          in   raw asynchronous RX line, idle high
//   sampled_bit        out  bit value for the SIPO serial input
//   data_is_available  out  one-cycle shift strobe for the SIPO
//   rx_done            out  one-cycle pulse, frame received with a valid stop bit
//   framing_error      out  one-cycle pulse, stop bit sampled low
//   busy               out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module uart_rx_sampling_controller #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLOCKS_PER_BIT   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic sampled_bit,
  output logic data_is_available,
  output logic rx_done,
  output logic framing_error,
  output logic busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(INPUT_DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic             s1_r;
  logic             rx_sync_r;
  logic             sample_s;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;

  logic             sampled_bit_s;
  logic             dav_s;
  logic             done_s;
  logic             ferr_s;
  logic             busy_s;

  // Two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r      <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      s1_r      <= serial_in;
      rx_sync_r <= s1_r;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // The history is the current rx_sync_r value and the two values before it.
  logic [1:0] hist_prev_r;
  logic [2:0] history_s;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Shift the synchronized line into the two older history slots
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_prev_r <= 2'b11;
    end else begin
      hist_prev_r <= {hist_prev_r[0], rx_sync_r};
    end
  end

  assign history_s = {hist_prev_r, rx_sync_r};
  assign sample_s  = majority3(history_s);
`else
  assign sample_s  = rx_sync_r;
`endif

  // Next-state, counter, bit index and output pulse decode
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    sampled_bit_s = sampled_bit;
    dav_s         = 1'b0;
    done_s        = 1'b0;
    ferr_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        idx_s = IDX_ZERO;
        if (!rx_sync_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          idx_s = IDX_ZERO;
          // A high sample at the start-bit centre is treated as a glitch.
          if (sample_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s         = CNT_ZERO;
          sampled_bit_s = sample_s;
          dav_s         = 1'b1;
          idx_s         = idx_r + IDX_ONE;
          if (idx_r == IDX_LAST) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = CNT_ZERO;
          if (sample_s) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_BREAK: begin
        // A held-low line must return high before a new start is accepted.
        cnt_s = CNT_ZERO;
        if (rx_sync_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      cnt_r             <= CNT_ZERO;
      idx_r             <= IDX_ZERO;
      sampled_bit       <= 1'b1;
      data_is_available <= 1'b0;
      rx_done           <= 1'b0;
      framing_error     <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state_r           <= state_s;
      cnt_r             <= cnt_s;
      idx_r             <= idx_s;
      sampled_bit       <= sampled_bit_s;
      data_is_available <= dav_s;
      rx_done           <= done_s;
      framing_error     <= ferr_s;
      busy              <= busy_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampling_controller.sv
// -----------------------------------------------------------------------------
// Testbench for uart_rx_sampling_controller.
// A frame-level reference model works from the recorded line and the timing
// rules. It uses the start edge T, bit-centre offsets, and a two-edge
// synchronizer latency. It predicts every output after every clock edge. A
// bench-side SIPO shift register rebuilds the received bytes from the DUT
// strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampling_controller;

  localparam int W   = 8;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic serial_in;
  logic sampled_bit;
  logic data_is_available;
  logic rx_done;
  logic framing_error;
  logic busy;

  int errors = 0;
  int checks = 0;

  uart_rx_sampling_controller #(
    .INPUT_DATA_WIDTH(W),
    .CLOCKS_PER_BIT  (CPB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .serial_in        (serial_in),
    .sampled_bit      (sampled_bit),
    .data_is_available(data_is_available),
    .rx_done          (rx_done),
    .framing_error    (framing_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  logic [4:0] obs;
  assign obs = {sampled_bit, data_is_available, rx_done, framing_error, busy};

  // Downstream SIPO: LSB-first assembly from the DUT strobe.
  logic [W-1:0] sipo;
  always @(posedge clk) begin
    if (data_is_available === 1'b1) sipo <= {sampled_bit, sipo[W-1:1]};
  end

  // ---------------- reference model ----------------
  bit         line_q[$];       // serial_in seen at each edge since time zero
  int         mdl_n    = 0;    // index of the edge being modelled
  int         mdl_r    = -100; // most recent reset edge
  int         mdl_mode = 0;    // 0 idle, 1 inside a frame, 2 break
  int         mdl_t    = 0;    // edge at which the start low was first seen
  logic       exp_sb   = 1'b1;
  logic [4:0] exp_v    = 5'b10000;

  // Synchronized line value seen by edge m: line two edges earlier, high after reset.
  function automatic bit seen(input int m);
    if ((m - 2) < 0 || (m - 2) <= mdl_r) return 1'b1;
    return line_q[m - 2];
  endfunction

  function automatic bit vote(input int m);
`ifdef RX_MAJORITY_VOTE_EN
    int ones;
    ones = int'(seen(m)) + int'(seen(m - 1)) + int'(seen(m - 2));
    return (ones >= 2);
`else
    return seen(m);
`endif
  endfunction

  task automatic model_step(input bit v, input bit r);
    int   d;
    int   base;
    bit   s;
    logic dav;
    logic done;
    logic ferr;
    line_q.push_back(v);
    dav  = 1'b0;
    done = 1'b0;
    ferr = 1'b0;
    if (r) begin
      mdl_r    = mdl_n;
      mdl_mode = 0;
      exp_sb   = 1'b1;
    end else begin
      s    = seen(mdl_n);
      base = 2 + CPB / 2;
      case (mdl_mode)
        0: if (!s) begin mdl_t = mdl_n - 2; mdl_mode = 1; end
        1: begin
          d = mdl_n - mdl_t;
          if (d == base) begin
            if (vote(mdl_n)) mdl_mode = 0;
          end else if (d > base && ((d - base) % CPB) == 0) begin
            if (((d - base) / CPB) <= W) begin
              exp_sb = vote(mdl_n);
              dav    = 1'b1;
            end else if (vote(mdl_n)) begin
              done     = 1'b1;
              mdl_mode = 0;
            end else begin
              ferr     = 1'b1;
              mdl_mode = 2;
            end
          end
        end
        2: if (s) mdl_mode = 0;
        default: mdl_mode = 0;
      endcase
    end
    exp_v = {exp_sb, dav, done, ferr, (mdl_mode != 0)};
    mdl_n++;
  endtask

  // ---------------- stimulus plumbing ----------------
  bit wave_q[$];
  bit wrst_q[$];

  int           g_dav, g_done, g_ferr, g_busy, g_first_dav, g_ferr_at;
  int           g_done_at_q[$];
  logic [W-1:0] g_sipo_q[$];

  task automatic clear_all();
    wave_q.delete();
    wrst_q.delete();
    g_dav = 0; g_done = 0; g_ferr = 0; g_busy = 0;
    g_first_dav = -1; g_ferr_at = -1;
    g_done_at_q.delete();
    g_sipo_q.delete();
  endtask

  task automatic add_idle(input int n, input bit v);
    for (int k = 0; k < n; k++) begin
      wave_q.push_back(v);
      wrst_q.push_back(1'b0);
    end
  endtask

  task automatic add_frame(input logic [W-1:0] d, input bit stop_bit);
    add_idle(CPB, 1'b0);
    for (int k = 0; k < W; k++) add_idle(CPB, d[k]);
    add_idle(CPB, stop_bit);
  endtask

  // Drive one edge, step the model, and record output events (no comparisons).
  task automatic drive(input bit v, input bit r, input int i);
    @(negedge clk);
    serial_in = v;
    reset     = r;
    @(posedge clk);
    model_step(v, r);
    #1;
    if (data_is_available === 1'b1) begin
      g_dav++;
      if (g_first_dav < 0) g_first_dav = i;
    end
    if (rx_done === 1'b1) begin
      g_done++;
      g_done_at_q.push_back(i);
      g_sipo_q.push_back(sipo);
    end
    if (framing_error === 1'b1) begin
      g_ferr++;
      g_ferr_at = i;
    end
    if (busy === 1'b1) g_busy++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_all();
    for (int k = 0; k < 4; k++) begin
      wave_q.push_back(1'($urandom_range(0, 1)));
      wrst_q.push_back(1'b1);
    end
    add_idle(6, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if (obs !== 5'b10000) begin
        errors++;
        $display("FAIL reset_values i=%0d got=%b exp=10000", i, obs);
      end
    end
  endtask

  task automatic test_frame_a5();
    int t0;
    clear_all();
    add_idle(10, 1'b1);
    t0 = 10;
    add_frame(8'hA5, 1'b1);
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL a5_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_first_dav !== t0 + 26) begin
      errors++; $display("FAIL a5_first_strobe got=%0d exp=%0d", g_first_dav, t0 + 26);
    end
    checks++;
    if (g_dav !== 8) begin errors++; $display("FAIL a5_strobes got=%0d exp=8", g_dav); end
    checks++;
    if (g_done !== 1 || g_ferr !== 0) begin
      errors++; $display("FAIL a5_pulses done=%0d ferr=%0d exp 1/0", g_done, g_ferr);
    end else begin
      checks++;
      if (g_done_at_q[0] !== t0 + 154) begin
        errors++; $display("FAIL a5_done_time got=%0d exp=%0d", g_done_at_q[0], t0 + 154);
      end
      checks++;
      if (g_sipo_q[0] !== 8'hA5) begin
        errors++; $display("FAIL a5_sipo got=%h exp=a5", g_sipo_q[0]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_all();
    add_idle(5, 1'b1);
    add_idle(5, 1'b0);
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_dav !== 0 || g_done !== 0 || g_ferr !== 0) begin
      errors++; $display("FAIL glitch_pulses dav=%0d done=%0d ferr=%0d exp 0/0/0", g_dav, g_done, g_ferr);
    end
    checks++;
    if (g_busy < 7 || g_busy > 9) begin
      errors++; $display("FAIL glitch_busy_len got=%0d exp=7..9", g_busy);
    end
  endtask

  task automatic test_framing();
    int t0;
    clear_all();
    add_idle(5, 1'b1);
    t0 = 5;
    add_frame(8'h3C, 1'b0);
    add_idle(100, 1'b0);
    add_idle(20, 1'b1);
    add_frame(8'h01, 1'b1);
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ferr_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_ferr !== 1 || g_ferr_at !== t0 + 154) begin
      errors++; $display("FAIL ferr_pulse count=%0d at=%0d exp 1 at %0d", g_ferr, g_ferr_at, t0 + 154);
    end
    checks++;
    if (g_dav !== 16) begin errors++; $display("FAIL ferr_no_restart strobes=%0d exp=16", g_dav); end
    checks++;
    if (g_done !== 1) begin
      errors++; $display("FAIL ferr_next_done got=%0d exp=1", g_done);
    end else begin
      checks++;
      if (g_sipo_q[0] !== 8'h01) begin
        errors++; $display("FAIL ferr_next_sipo got=%h exp=01", g_sipo_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    add_idle(5, 1'b1);
    add_frame(8'hFF, 1'b1);
    add_frame(8'h00, 1'b1);
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_done !== 2) begin
      errors++; $display("FAIL b2b_done got=%0d exp=2", g_done);
    end else begin
      checks++;
      if (g_done_at_q[1] - g_done_at_q[0] !== 160) begin
        errors++; $display("FAIL b2b_spacing got=%0d exp=160", g_done_at_q[1] - g_done_at_q[0]);
      end
      checks++;
      if (g_sipo_q[0] !== 8'hFF || g_sipo_q[1] !== 8'h00) begin
        errors++; $display("FAIL b2b_sipo got=%h,%h exp=ff,00", g_sipo_q[0], g_sipo_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_all();
    add_idle(5, 1'b1);
    t0 = 5;
    add_idle(60, 1'b0);
    add_idle(40, 1'b1);
    wrst_q[t0 + 60] = 1'b1;
    add_frame(8'h55, 1'b1);
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rstmid_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
      if (i == t0 + 60) begin
        checks++;
        if (obs !== 5'b10000) begin
          errors++; $display("FAIL rstmid_values got=%b exp=10000", obs);
        end
      end
    end
    checks++;
    if (g_done !== 1 || g_ferr !== 0) begin
      errors++; $display("FAIL rstmid_pulses done=%0d ferr=%0d exp 1/0", g_done, g_ferr);
    end else begin
      checks++;
      if (g_sipo_q[0] !== 8'h55) begin
        errors++; $display("FAIL rstmid_sipo got=%h exp=55", g_sipo_q[0]);
      end
    end
  endtask

  task automatic test_glitch_vote();
    int           t0;
    logic [W-1:0] want;
    clear_all();
    add_idle(5, 1'b1);
    t0 = 5;
    add_frame(8'h00, 1'b1);
    add_idle(30, 1'b1);
    wave_q[t0 + 72] = 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL vote_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_done !== 1) begin
      errors++; $display("FAIL vote_done got=%0d exp=1", g_done);
    end else begin
      checks++;
      if (g_sipo_q[0] !== want) begin
        errors++; $display("FAIL vote_sipo got=%h exp=%h", g_sipo_q[0], want);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [W-1:0] exp_bytes[$];
    logic [W-1:0] d;
    bit           ok;
    int           n_bad;
    clear_all();
    n_bad = 0;
    add_idle(5, 1'b1);
    for (int f = 0; f < 8; f++) begin
      d  = W'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      add_frame(d, ok);
      if (ok) begin
        exp_bytes.push_back(d);
        add_idle($urandom_range(0, 12), 1'b1);
      end else begin
        n_bad++;
        add_idle($urandom_range(3, 15), 1'b1);
      end
    end
    add_idle(30, 1'b1);
    for (int i = 0; i < wave_q.size(); i++) begin
      drive(wave_q[i], wrst_q[i], i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand_cycle i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if (g_done !== exp_bytes.size() || g_ferr !== n_bad) begin
      errors++;
      $display("FAIL rand_counts done=%0d ferr=%0d exp %0d/%0d", g_done, g_ferr, exp_bytes.size(), n_bad);
    end else begin
      for (int k = 0; k < exp_bytes.size(); k++) begin
        checks++;
        if (g_sipo_q[k] !== exp_bytes[k]) begin
          errors++; $display("FAIL rand_sipo k=%0d got=%h exp=%h", k, g_sipo_q[k], exp_bytes[k]);
        end
      end
    end
  endtask

  initial begin
    serial_in = 1'b1;
    reset     = 1'b1;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_glitch_vote();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampling_controller.md
# uart_rx_sampling_controller

Receive-side sequencer for the UART. It synchronizes the raw line, detects and qualifies the start bit, and locates each bit centre with a clock counter. At each centre it issues a one-cycle shift strobe and the sampled bit to the downstream SIPO shift register, which assembles the LSB-first byte. After the byte it checks the stop bit and reports frame completion or a framing error.

## Interface
- INPUT_DATA_WIDTH, 8, data bits per frame; must match the SIPO register width.
- CLOCKS_PER_BIT, 16, clk cycles per bit period; even, ≥4.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  raw asynchronous RX line; idle high.
- sampled_bit  output  1  bit value for the SIPO `serial_in` port.
- data_is_available  output  1  one-cycle shift strobe for the SIPO.
- rx_done  output  1  one-cycle pulse: frame received, stop bit valid.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

## Operation
- Two-flop synchronizer: serial_in → s1 → rx_sync. A 3-bit history register holds the last three rx_sync values.
- The sample value is defined by the configuration macro (see Configuration).
- The counter is $clog2(CLOCKS_PER_BIT) bits wide. The bit index is $clog2(INPUT_DATA_WIDTH+1) bits wide.
- State machine:
  - IDLE: if rx_sync==0, go to START with counter=0.
  - START: counter increments each cycle. At counter==CLOCKS_PER_BIT/2-1, evaluate the sample:
    - 0: go to DATA with counter=0 and bit index=0.
    - 1: glitch; go to IDLE with no outputs.
  - DATA: at counter==CLOCKS_PER_BIT-1, evaluate the sample, then:
    - Register it to sampled_bit.
    - Pulse data_is_available.
    - Set counter=0 and increment the bit index.
    - After bit index INPUT_DATA_WIDTH-1, go to STOP.
  - STOP: at counter==CLOCKS_PER_BIT-1, evaluate the sample:
    - 1: pulse rx_done; go to IDLE.
    - 0: pulse framing_error; go to BREAK.
  - BREAK: stay until rx_sync==1, then go to IDLE. A held-low line never retriggers a start.
- The SIPO content on a framing error is undefined to consumers. The block does not suppress shifts already issued.
- The counter never wraps outside its terminal compare: it is cleared at every evaluation and on every state entry.

## Timing
- Reset:
  - State=IDLE; counter=0; bit index=0.
  - s1, rx_sync and history = all ones.
  - sampled_bit=1; data_is_available=0; rx_done=0; framing_error=0; busy=0.
- Reset has priority over any state. Asserting it mid-frame aborts the frame; there is no pulse on the following cycle.
- All outputs are registered. Pulses are high for exactly the one cycle after the evaluation edge.
- sampled_bit is valid in the same cycle data_is_available is high, and holds until the next evaluation.
- Let T be the first edge at which serial_in is sampled low:
  - START is entered at T+2.
  - Data bit k (k=0..W-1) is evaluated at T+2+CLOCKS_PER_BIT/2+CLOCKS_PER_BIT·(k+1).
  - The stop bit is evaluated at T+2+CLOCKS_PER_BIT/2+CLOCKS_PER_BIT·(W+1).
  - With defaults, strobes appear after edges T+26, T+42, …, T+138. rx_done or framing_error appears after edge T+154.
- rx_done and data_is_available are never high in the same cycle.
- busy rises the cycle after entry to START. It falls the cycle after return to IDLE.
- A new start is accepted on the first IDLE cycle with rx_sync==0. Back-to-back frames with a one-bit stop are supported.

## Configuration
- RX_MAJORITY_VOTE_EN defined: the sample is the majority of the three history bits (rx_sync at the evaluation edge and the two prior edges). Evaluation timing is unchanged.
- Undefined: the sample is rx_sync at the evaluation edge; the history register may be removed.

## Test plan
- Defaults, frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop high) → 8 strobes with sampled_bit sequence 1,0,1,0,0,1,0,1 at the cycle offsets above. SIPO holds 0xA5. rx_done pulses once, after T+154. framing_error stays 0.
- Line low for 5 cycles, then high → START entered and aborted to IDLE. No strobe, no rx_done, busy high for about 7 cycles.
- Frame 0x3C with the stop bit held low → framing_error pulses after T+154, then state is BREAK. Line kept low 100 cycles → no new START. Line high, then a 0x01 frame → rx_done and SIPO=0x01.
- Two back-to-back frames 0xFF and 0x00 with a single stop bit → two rx_done pulses 160 cycles apart; SIPO shows 0xFF then 0x00.
- reset asserted for one cycle at T+60 mid-frame → all outputs at reset values the next cycle. No rx_done for that frame. A following 0x55 frame is received correctly.
- With RX_MAJORITY_VOTE_EN, frame 0x00 with a one-cycle high glitch at the bit-3 evaluation edge → sampled_bit=0 and SIPO=0x00. Without the macro → bit 3 reads 1 and SIPO=0x08.
